// File: rtl/point_bitmap_collector.sv
// Collects 3-bit (x, y) points of one frame into an 8x8 bitmap, counts distinct
// and repeated points, then streams the bitmap out row by row over valid/ready.
module point_bitmap_collector #(
    parameter logic CLEAR_AFTER_DUMP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       po_in,
    input  logic [2:0] xi,
    input  logic [2:0] yi,
    input  logic       frame_done,
    input  logic       row_ready,
    output logic       row_valid,
    output logic [7:0] row_data,
    output logic [2:0] row_idx,
    output logic [6:0] point_count,
    output logic [6:0] dup_count,
    output logic       dump_busy,
    output logic       frame_ack,
    output logic       drop_err,
    output logic [1:0] o_dbg_state
);

    // Row handshake: a row moves when row_valid and row_ready are both high at a
    // rising clk edge; row_idx/row_data hold still while row_ready is low.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DUMP    = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t      r_state;
    logic [63:0] r_bitmap;
    logic        r_row_valid;
    logic [2:0]  r_row_idx;
    logic [6:0]  r_point_count;
    logic [6:0]  r_dup_count;
    logic        r_dump_busy;
    logic        r_frame_ack;
    logic        r_drop_err;

    logic [5:0]  w_bit_idx;
    logic        w_record;
    logic        w_start_dump;

    assign w_bit_idx    = {yi, xi};
    assign w_record     = po_in && ((r_state == IDLE) || (r_state == COLLECT));
    assign w_start_dump = frame_done && ((r_state == IDLE) || (r_state == COLLECT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_bitmap      <= '0;
            r_row_valid   <= 1'b0;
            r_row_idx     <= '0;
            r_point_count <= '0;
            r_dup_count   <= '0;
            r_dump_busy   <= 1'b0;
            r_frame_ack   <= 1'b0;
            r_drop_err    <= 1'b0;
        end else begin
            // A point is committed before any dump starting on the same edge.
            if (w_record) begin
                if (r_bitmap[w_bit_idx]) begin
                    if (r_dup_count != 7'd127)
                        r_dup_count <= r_dup_count + 7'd1;
                end else begin
                    r_bitmap[w_bit_idx] <= 1'b1;
                    r_point_count       <= r_point_count + 7'd1;
                end
            end

            case (r_state)
                IDLE, COLLECT: begin
                    if (w_start_dump) begin
                        r_state     <= DUMP;
                        r_row_valid <= 1'b1;
                        r_row_idx   <= '0;
                        r_dump_busy <= 1'b1;
                    end else if (po_in) begin
                        r_state <= COLLECT;
                    end
                end
                DUMP: begin
                    if (po_in)
                        r_drop_err <= 1'b1;
                    if (row_ready) begin
                        if (r_row_idx == 3'd7) begin
                            r_state     <= ACK;
                            r_row_valid <= 1'b0;
                            r_row_idx   <= '0;
                            r_frame_ack <= 1'b1;
                        end else begin
                            r_row_idx <= r_row_idx + 3'd1;
                        end
                    end
                end
                ACK: begin
                    if (po_in)
                        r_drop_err <= 1'b1;
                    r_state     <= IDLE;
                    r_frame_ack <= 1'b0;
                    r_dump_busy <= 1'b0;
                    if (CLEAR_AFTER_DUMP) begin
                        r_bitmap      <= '0;
                        r_point_count <= '0;
                        r_dup_count   <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Row data is forced to zero outside a dump so idle outputs read as zero.
    assign row_data    = r_row_valid ? r_bitmap[{r_row_idx, 3'b000} +: 8] : 8'h00;
    assign row_valid   = r_row_valid;
    assign row_idx     = r_row_idx;
    assign point_count = r_point_count;
    assign dup_count   = r_dup_count;
    assign dump_busy   = r_dump_busy;
    assign frame_ack   = r_frame_ack;
    assign drop_err    = r_drop_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_point_bitmap_collector.sv
// Randomized scoreboard bench for point_bitmap_collector: a bitmap/count model
// queues expected rows and a negedge monitor checks every accepted row and ack.
module tb_point_bitmap_collector;

  localparam logic CLEAR = 1'b1;

  logic       clk;
  logic       reset;
  logic       po_in;
  logic [2:0] xi;
  logic [2:0] yi;
  logic       frame_done;
  logic       row_ready;
  logic       row_valid;
  logic [7:0] row_data;
  logic [2:0] row_idx;
  logic [6:0] point_count;
  logic [6:0] dup_count;
  logic       dump_busy;
  logic       frame_ack;
  logic       drop_err;
  logic [1:0] dbg_state;

  point_bitmap_collector #(.CLEAR_AFTER_DUMP(CLEAR)) dut (
    .clk(clk), .reset(reset), .po_in(po_in), .xi(xi), .yi(yi),
    .frame_done(frame_done), .row_ready(row_ready), .row_valid(row_valid),
    .row_data(row_data), .row_idx(row_idx), .point_count(point_count),
    .dup_count(dup_count), .dump_busy(dump_busy), .frame_ack(frame_ack),
    .drop_err(drop_err), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: plain 64-entry bitmap plus counters
  bit   model_bm[64];
  int   model_pc = 0;
  int   model_dc = 0;
  int   exp_pc_last = 0;
  int   exp_dc_last = 0;
  logic exp_drop = 1'b0;

  logic [10:0] exp_q[$];
  int          exp_ack = 0;
  int          ack_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) model_bm[i] = 1'b0;
    model_pc = 0;
    model_dc = 0;
  endfunction

  function automatic void model_point(input int x, input int y);
    if (model_bm[y * 8 + x]) begin
      if (model_dc < 127) model_dc++;
    end else begin
      model_bm[y * 8 + x] = 1'b1;
      model_pc++;
    end
  endfunction

  function automatic void model_dump();
    logic [7:0] d;
    logic [2:0] r3;
    for (int r = 0; r < 8; r++) begin
      for (int x = 0; x < 8; x++) d[x] = model_bm[r * 8 + x];
      r3 = r[2:0];
      exp_q.push_back({r3, d});
    end
    exp_ack++;
    exp_pc_last = model_pc;
    exp_dc_last = model_dc;
    if (CLEAR) model_clear();
  endfunction

  // monitor / scoreboard
  int          since_xfer = 100;
  int          last_idx = 0;
  logic        hold_v = 1'b0;
  logic [10:0] hold_val;

  always @(negedge clk) begin
    logic [10:0] exp_row;
    if (reset) begin
      since_xfer = 100;
      hold_v = 1'b0;
    end else begin
      since_xfer++;
      if (frame_ack) begin
        checks++;
        ack_seen++;
        if (exp_ack == 0 || since_xfer != 1 || last_idx != 7) begin
          errors++;
          $display("FAIL frame_ack: pending=%0d cycles_after_xfer=%0d last_idx=%0d, expected pending>0 cycles=1 idx=7",
                   exp_ack, since_xfer, last_idx);
        end
        if (exp_ack > 0) exp_ack--;
      end
      if (row_valid) begin
        check("dump_busy_in_dump", dump_busy, 1);
        if (hold_v) check("row_stable", {row_idx, row_data}, hold_val);
        if (row_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL row_unexpected: got idx=%0d data=%02h expected no row", row_idx, row_data);
          end else begin
            exp_row = exp_q.pop_front();
            if ({row_idx, row_data} !== exp_row) begin
              errors++;
              $display("FAIL row: got idx=%0d data=%02h expected idx=%0d data=%02h",
                       row_idx, row_data, exp_row[10:8], exp_row[7:0]);
            end
          end
          since_xfer = 0;
          last_idx = row_idx;
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1;
          hold_val = {row_idx, row_data};
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_point(input int x, input int y);
    po_in = 1'b1;
    xi = x[2:0];
    yi = y[2:0];
    model_point(x, y);
    tick();
    po_in = 1'b0;
  endtask

  // Ends the frame, optionally with a point in the same cycle as frame_done.
  task automatic end_frame(input bit with_point, input int x, input int y);
    if (with_point) begin
      po_in = 1'b1;
      xi = x[2:0];
      yi = y[2:0];
      model_point(x, y);
    end
    frame_done = 1'b1;
    model_dump();
    tick();
    po_in = 1'b0;
    frame_done = 1'b0;
    check("point_count_frame", point_count, exp_pc_last);
    check("dup_count_frame", dup_count, exp_dc_last);
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low 5 cycles on row 2,
  // 3: point (7,7) plus frame_done injected while row 3 is shown
  task automatic run_dump(input int mode);
    int   start;
    int   n;
    bit   done_special;
    logic [7:0] hv;
    start = ack_seen;
    n = 0;
    done_special = 1'b0;
    while (ack_seen == start && n < 300) begin
      row_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 2 && !done_special && row_valid && row_idx == 3'd2) begin
        row_ready = 1'b0;
        hv = row_data;
        for (int k = 0; k < 5; k++) begin
          tick();
          check("hold_valid", row_valid, 1);
          check("hold_idx", row_idx, 2);
          check("hold_data", row_data, hv);
        end
        n += 5;
        row_ready = 1'b1;
        done_special = 1'b1;
      end
      if (mode == 3 && !done_special && row_valid && row_idx == 3'd3) begin
        po_in = 1'b1;
        xi = 3'd7;
        yi = 3'd7;
        frame_done = 1'b1;
        exp_drop = 1'b1;
        done_special = 1'b1;
      end
      tick();
      po_in = 1'b0;
      frame_done = 1'b0;
      n++;
    end
    row_ready = 1'b1;
    if (ack_seen == start) begin
      checks++;
      errors++;
      $display("FAIL dump_timeout: got no frame_ack within %0d cycles expected one", n);
    end
    tick();
    check("point_count_after", point_count, model_pc);
    check("dup_count_after", dup_count, model_dc);
    check("drop_err", drop_err, exp_drop);
    check("rows_pending", exp_q.size(), 0);
    check("row_valid_idle", row_valid, 0);
  endtask

  task automatic random_frame(input int npts, input int mode);
    bit combine;
    combine = 1'($urandom_range(0, 1));
    for (int i = 0; i < npts - (combine ? 1 : 0); i++)
      send_point($urandom_range(0, 7), $urandom_range(0, 3));
    if (combine) end_frame(1'b1, $urandom_range(0, 7), $urandom_range(0, 3));
    else end_frame(1'b0, 0, 0);
    run_dump(mode);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    po_in = 1'b0;
    xi = 3'd0;
    yi = 3'd0;
    frame_done = 1'b0;
    row_ready = 1'b1;
    model_clear();
    tick();
    tick();
    check("rst_row_valid", row_valid, 0);
    check("rst_row_data", row_data, 0);
    check("rst_row_idx", row_idx, 0);
    check("rst_point_count", point_count, 0);
    check("rst_dup_count", dup_count, 0);
    check("rst_dump_busy", dump_busy, 0);
    check("rst_frame_ack", frame_ack, 0);
    check("rst_drop_err", drop_err, 0);
    reset = 1'b0;
    tick();

    // three points, rows 0x03, 0x01, then zeros
    send_point(0, 0);
    send_point(1, 0);
    send_point(0, 1);
    check("pc_three", point_count, 3);
    end_frame(1'b0, 0, 0);
    run_dump(0);

    // repeated point
    send_point(2, 3);
    send_point(2, 3);
    send_point(2, 3);
    check("pc_dup", point_count, 1);
    check("dc_dup", dup_count, 2);
    end_frame(1'b0, 0, 0);
    run_dump(0);

    // back-pressure on row 2
    random_frame(10, 2);

    // dropped point and ignored frame_done during dump
    send_point(1, 1);
    send_point(3, 5);
    end_frame(1'b0, 0, 0);
    run_dump(3);

    // empty frame
    end_frame(1'b0, 0, 0);
    run_dump(0);

    // random frames with random back-pressure
    for (int f = 0; f < 6; f++)
      random_frame($urandom_range(1, 40), 1);

    // dup counter saturation
    for (int i = 0; i < 130; i++) send_point(4, 4);
    check("dc_saturate", dup_count, 127);
    end_frame(1'b0, 0, 0);
    run_dump(0);

    // reset in the middle of a dump
    random_frame(8, 0);
    send_point(5, 6);
    send_point(6, 2);
    end_frame(1'b0, 0, 0);
    n = 0;
    while (!(row_valid && row_idx == 3'd4) && n < 50) begin
      tick();
      n++;
    end
    check("reach_row4", {row_valid, row_idx}, {1'b1, 3'd4});
    reset = 1'b1;
    tick();
    exp_q.delete();
    exp_ack = 0;
    exp_drop = 1'b0;
    model_clear();
    check("mid_rst_row_valid", row_valid, 0);
    check("mid_rst_row_data", row_data, 0);
    check("mid_rst_row_idx", row_idx, 0);
    check("mid_rst_point_count", point_count, 0);
    check("mid_rst_dump_busy", dump_busy, 0);
    check("mid_rst_frame_ack", frame_ack, 0);
    check("mid_rst_drop_err", drop_err, 0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("no_late_ack", ack_seen > 0 ? 32'(exp_ack) : 0, 0);
    random_frame(12, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/point_bitmap_collector.md
POINT_BITMAP_COLLECTOR -- requirements
Module: point_bitmap_collector

Interface
REQ-001 SHALL have parameter CLEAR_AFTER_DUMP, default 1, meaning that the bitmap and counters clear after a completed dump (0 = retain until reset).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on clk.
REQ-004 SHALL have port po_in  input  1  point strobe from the upstream point finder; one point per cycle while high.
REQ-005 SHALL have port xi  input  3  x coordinate of the point, valid when po_in=1.
REQ-006 SHALL have port yi  input  3  y coordinate of the point, valid when po_in=1.
REQ-007 SHALL have port frame_done  input  1  end-of-frame pulse from the upstream done flag.
REQ-008 SHALL have port row_ready  input  1  downstream accepts row_data this cycle.
REQ-009 SHALL have port row_valid  output  1  row_data/row_idx hold a valid row.
REQ-010 SHALL have port row_data  output  8  bitmap row; bit x = pixel (x, row_idx).
REQ-011 SHALL have port row_idx  output  3  row number (y) of row_data.
REQ-012 SHALL have port point_count  output  7  number of distinct points in the current frame (0..64).
REQ-013 SHALL have port dup_count  output  7  number of repeated points in the current frame, saturating at 127.
REQ-014 SHALL have port dump_busy  output  1  high in DUMP and ACK states.
REQ-015 SHALL have port frame_ack  output  1  one-cycle pulse after the last row is accepted.
REQ-016 SHALL have port drop_err  output  1  sticky flag: a point arrived while dump_busy=1.

Function
REQ-017 SHALL implement states IDLE, COLLECT, DUMP and ACK, with an internal 64-bit bitmap.
REQ-018 IDLE: on po_in=1, the point SHALL be recorded and the state SHALL move to COLLECT; on frame_done=1, the state SHALL move to DUMP (an empty frame dumps 8 zero rows).
REQ-019 Recording a point SHALL set bit bitmap[yi*8+xi] at the sampling edge; point_count and dup_count SHALL reflect the point on the next cycle (1-cycle latency).
REQ-020 If the bit is already set, dup_count SHALL increment (saturating at 127) and point_count SHALL be unchanged; otherwise point_count SHALL increment.
REQ-021 In COLLECT, frame_done=1 SHALL move the state to DUMP next cycle; if po_in=1 in the same cycle, that point SHALL be recorded before the dump.
REQ-022 DUMP SHALL drive row_valid=1, row_idx starting at 0, and row_data = bitmap row row_idx, combinationally from the registered row_idx.
REQ-023 A transfer SHALL occur when row_valid=1 and row_ready=1; on a transfer, row_idx SHALL increment. row_data/row_idx SHALL stay stable while row_ready=0.
REQ-024 A transfer with row_idx=7 SHALL move the state to ACK, with row_valid=0 next cycle and row_idx wrapping to 0.
REQ-025 ACK SHALL last exactly 1 cycle, with frame_ack=1; when CLEAR_AFTER_DUMP=1 it SHALL clear the bitmap, point_count and dup_count; it SHALL then go to IDLE.
REQ-026 po_in=1 in DUMP or ACK SHALL be ignored (bitmap and counts unchanged) and SHALL set drop_err; drop_err SHALL clear only on reset.
REQ-027 frame_done in DUMP or ACK SHALL be ignored; frame_done and po_in in IDLE in the same cycle SHALL record the point, then dump.
REQ-028 Each row SHALL be presented for at least 1 cycle; with row_ready held at 1, the dump SHALL take 8 cycles plus 1 ACK cycle.

Reset
REQ-029 On reset=1 at a clock edge: state=IDLE, bitmap=0, row_valid=0, row_data=0, row_idx=0, point_count=0, dup_count=0, dump_busy=0, frame_ack=0, drop_err=0.
REQ-030 Reset SHALL take priority over all inputs, including mid-dump; an interrupted dump SHALL emit no further rows and no frame_ack.

Verification
REQ-031 Points (0,0),(1,0),(0,1) with frame_done after the last point and row_ready=1 -> rows 0..7 = 0x03,0x01,0x00 x6; point_count=3; frame_ack 1 cycle after the row-7 transfer.
REQ-032 Point (2,3) sent three times -> point_count=1, dup_count=2, row 3 = 0x04.
REQ-033 row_ready held low for 5 cycles during row 2 -> row_valid=1, row_idx=2 and row_data stable for all 5 cycles; no row skipped.
REQ-034 po_in=1 with (7,7) during DUMP -> drop_err=1 and row 7 = 0x00 (point not recorded).
REQ-035 frame_done with no points -> 8 rows of 0x00 then frame_ack; counts stay 0.
REQ-036 Reset asserted at row_idx=4 -> next cycle row_valid=0, all outputs 0, no frame_ack; a new frame then collects correctly.
